// File: rtl/frame_streamer_pkg.sv
// Shared types and helpers for the frame streamer.
package frame_streamer_pkg;

  // Bits needed to index v distinct values (ceil(log2(v))).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, READ, GAP, DRAIN} fs_state_t;

endpackage

// File: rtl/vld_delay.sv
// Fixed-depth shift register that keeps read tags aligned with memory read data.
module vld_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] vld_pipe;

  // Shift tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH-1];

endmodule

// File: rtl/frame_streamer.sv
// Raster-order frame source: reads a frame from pixel memory and emits a valid/data stream.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int CH_NUM      = 4,
  parameter int MEM_LATENCY = 2,
  parameter int ROW_GAP_MAX = 15,
  localparam int HW     = clog2(FRAME_H_MAX) + 1,
  localparam int WW     = clog2(FRAME_W_MAX) + 1,
  localparam int GW     = clog2(ROW_GAP_MAX) + 1,
  localparam int ADDR_W = clog2(FRAME_H_MAX * FRAME_W_MAX)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [HW-1:0]                        frame_h,
  input  logic [WW-1:0]                        frame_w,
  input  logic [GW-1:0]                        row_gap,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_rd,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [CH_NUM*DIN_WIDTH-1:0]          mem_rdata,
  output logic                                 fout_start,
  output logic                                 dout_vld,
  output logic [CH_NUM-1:0][DIN_WIDTH-1:0]     dout
);

  // Shared gap / drain counter must reach both row_gap-1 and MEM_LATENCY.
  localparam int CW = clog2(ROW_GAP_MAX + MEM_LATENCY + 1) + 1;

  fs_state_t         state, state_nxt;
  logic [HW-1:0]     h_q, y_q;
  logic [WW-1:0]     w_q, x_q;
  logic [GW-1:0]     g_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rej_q;
  logic              cfg_bad, accept, row_end, last_row, gap_end, drain_end;
  logic              dl_first, dl_vld;

  assign cfg_bad   = (frame_h == '0) || (frame_w == '0) ||
                     (frame_h > HW'(FRAME_H_MAX)) || (frame_w > WW'(FRAME_W_MAX)) ||
                     (row_gap > GW'(ROW_GAP_MAX));
  assign accept    = (state == IDLE) && start && !cfg_bad;
  assign row_end   = (x_q == w_q - WW'(1));
  assign last_row  = (y_q == h_q - HW'(1));
  assign gap_end   = (cnt_q == CW'(g_q) - CW'(1));
  // Drain lasts MEM_LATENCY+1 cycles so done lands on the final dout_vld.
  assign drain_end = (cnt_q == CW'(MEM_LATENCY));
  assign mem_addr  = addr_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    busy      = (state != IDLE);
    done      = rej_q;
    case (state)
      IDLE:  if (accept) state_nxt = READ;
      READ: begin
        mem_rd = 1'b1;
        if (row_end) begin
          if (last_row)         state_nxt = DRAIN;
          else if (g_q != '0)   state_nxt = GAP;
        end
      end
      GAP:   if (gap_end) state_nxt = READ;
      DRAIN: if (drain_end) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, raster counters and running address (no multiplier).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0; w_q <= '0; g_q <= '0;
      x_q <= '0; y_q <= '0; addr_q <= '0;
      cnt_q <= '0; rej_q <= 1'b0;
    end else begin
      rej_q <= (state == IDLE) && start && cfg_bad;
      cnt_q <= (state_nxt == state) ? cnt_q + CW'(1) : '0;
      if (accept) begin
        h_q <= frame_h; w_q <= frame_w; g_q <= row_gap;
        x_q <= '0; y_q <= '0; addr_q <= '0;
      end else if (state == READ) begin
        x_q <= row_end ? '0 : x_q + WW'(1);
        if (row_end) y_q <= y_q + HW'(1);
        // Hold on the last pixel so the address never exceeds H*W-1.
        if (!(row_end && last_row)) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  vld_delay #(.DEPTH(MEM_LATENCY), .W(2)) u_vld_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({mem_rd && (x_q == '0) && (y_q == '0), mem_rd}),
    .q       ({dl_first, dl_vld})
  );

  // Output register: capture read data when its tag arrives, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_vld   <= 1'b0;
      fout_start <= 1'b0;
      dout       <= '0;
    end else begin
      dout_vld   <= dl_vld;
      fout_start <= dl_vld && dl_first;
      if (dl_vld) dout <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks.
module tb_frame_streamer;

  typedef struct { bit have; bit ok; int t0, h, w, g; } frm_t;
  typedef struct { bit rd, vld, fst, done, busy; int addr, daddr; } exp_t;

  logic        clk = 0, reset_n = 1;
  logic        start_a = 0, start_b = 0;
  logic [8:0]  fh_a = 0, fw_a = 0, fh_b = 0, fw_b = 0;
  logic [4:0]  rg_a = 0, rg_b = 0;
  logic        busy_a, done_a, rd_a, fs_a, vld_a, busy_b, done_b, rd_b, fs_b, vld_b;
  logic [15:0] addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b, dout_a, dout_b;
  logic [31:0] rqa, rqb, mpa0, mpa1, mpb0;
  int cyc = 0, checks = 0, failures = 0;
  int t0, done_c, done_cnt, fst_cnt, fst_dat, busy_seen;
  int vq[$], vcq[$], rcq[$], raq[$];
  int rd_cnt_b, vld_cnt_b, done_c_b, last_addr_b;
  frm_t fa = '{default: 0}, fb = '{default: 0};
  logic [31:0] dexp_a = 0, dexp_b = 0;
  int off[12] = '{0, 1, 2, 3, 6, 7, 8, 9, 12, 13, 14, 15};

  frame_streamer #(.MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .frame_h(fh_a), .frame_w(fw_a),
    .row_gap(rg_a), .busy(busy_a), .done(done_a), .mem_rd(rd_a), .mem_addr(addr_a),
    .mem_rdata(rdata_a), .fout_start(fs_a), .dout_vld(vld_a), .dout(dout_a));

  frame_streamer #(.MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .frame_h(fh_b), .frame_w(fw_b),
    .row_gap(rg_b), .busy(busy_b), .done(done_b), .mem_rd(rd_b), .mem_addr(addr_b),
    .mem_rdata(rdata_b), .fout_start(fs_b), .dout_vld(vld_b), .dout(dout_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memories, mem[a] = a; non-read cycles push junk into the pipe.
  always @(negedge clk) begin
    rqa = rd_a ? 32'(addr_a) : $urandom;
    rqb = rd_b ? 32'(addr_b) : $urandom;
  end
  always @(posedge clk) begin
    mpa0 <= rqa; mpa1 <= mpa0; mpb0 <= rqb;
  end
  assign rdata_a = mpa1;
  assign rdata_b = mpb0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit cfg_ok(input int h, input int w, input int g);
    return h >= 1 && h <= 224 && w >= 1 && w <= 224 && g <= 15;
  endfunction

  // Frame schedule from first principles: reads at t0+1 in rows of W, G idle after each row.
  function automatic exp_t model(input frm_t f, input int L, input int c);
    exp_t e;
    int per, rel, tdone;
    e = '{default: 0};
    if (!f.have) return e;
    if (!f.ok) begin
      e.done = (c == f.t0 + 1);
      return e;
    end
    per   = f.w + f.g;
    tdone = f.t0 + 1 + f.h * f.w + (f.h - 1) * f.g + L;
    e.busy = (c > f.t0) && (c <= tdone);
    e.done = (c == tdone);
    rel = c - f.t0 - 1;
    if (rel >= 0 && rel / per < f.h && rel % per < f.w) begin
      e.rd = 1; e.addr = (rel / per) * f.w + rel % per;
    end
    rel = c - L - 1 - f.t0 - 1;
    if (rel >= 0 && rel / per < f.h && rel % per < f.w) begin
      e.vld = 1; e.daddr = (rel / per) * f.w + rel % per; e.fst = (e.daddr == 0);
    end
    return e;
  endfunction

  function automatic bit idle(input frm_t f, input int L, input int c);
    if (!f.have) return 1;
    if (!f.ok) return c >= f.t0 + 1;
    return c >= f.t0 + 2 + f.h * f.w + (f.h - 1) * f.g + L;
  endfunction

  // Compare DUT A to the model every cycle and record its stream.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!reset_n) begin
      fa.have = 0; dexp_a = 0;
      chk("a_rst_ctl", {busy_a, done_a, rd_a, fs_a, vld_a}, 0);
      chk("a_rst_dout", dout_a, 0);
    end else begin
      e = model(fa, 2, cyc);
      chk("a_mem_rd", rd_a, e.rd);
      if (e.rd) chk("a_mem_addr", addr_a, e.addr);
      chk("a_dout_vld", vld_a, e.vld);
      chk("a_fout_start", fs_a, e.fst);
      chk("a_done", done_a, e.done);
      chk("a_busy", busy_a, e.busy);
      if (e.vld) dexp_a = 32'(e.daddr);
      chk("a_dout", dout_a, dexp_a);
      if (vld_a) begin vq.push_back(int'(dout_a)); vcq.push_back(cyc); end
      if (rd_a) begin rcq.push_back(cyc); raq.push_back(int'(addr_a)); end
      if (fs_a) begin fst_cnt++; fst_dat = int'(dout_a); end
      if (done_a) begin done_cnt++; done_c = cyc; end
      if (busy_a) busy_seen = 1;
      if (start_a && idle(fa, 2, cyc)) begin
        fa.have = 1; fa.ok = cfg_ok(fh_a, fw_a, rg_a); fa.t0 = cyc;
        fa.h = fh_a; fa.w = fw_a; fa.g = rg_a;
      end
    end
  end

  // Same for DUT B (latency 1), with lighter recording.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset_n) begin
      fb.have = 0; dexp_b = 0;
      chk("b_rst_ctl", {busy_b, done_b, rd_b, fs_b, vld_b}, 0);
    end else begin
      e = model(fb, 1, cyc);
      chk("b_mem_rd", rd_b, e.rd);
      if (e.rd) chk("b_mem_addr", addr_b, e.addr);
      chk("b_dout_vld", vld_b, e.vld);
      chk("b_fout_start", fs_b, e.fst);
      chk("b_done", done_b, e.done);
      chk("b_busy", busy_b, e.busy);
      if (e.vld) dexp_b = 32'(e.daddr);
      chk("b_dout", dout_b, dexp_b);
      if (rd_b) begin rd_cnt_b++; last_addr_b = int'(addr_b); end
      if (vld_b) vld_cnt_b++;
      if (done_b) done_c_b = cyc;
      if (start_b && idle(fb, 1, cyc)) begin
        fb.have = 1; fb.ok = cfg_ok(fh_b, fw_b, rg_b); fb.t0 = cyc;
        fb.h = fh_b; fb.w = fw_b; fb.g = rg_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    vq.delete(); vcq.delete(); rcq.delete(); raq.delete();
    done_c = -1; done_cnt = 0; fst_cnt = 0; fst_dat = -1; busy_seen = 0;
  endtask

  task automatic inject(input int h, input int w, input int g);
    fh_a = 9'(h); fw_a = 9'(w); rg_a = 5'(g); start_a = 1;
    tick();
    start_a = 0;
  endtask

  task automatic pulse_a(input int h, input int w, input int g);
    t0 = cyc;
    inject(h, w, g);
  endtask

  task automatic wait_idle_a(input int budget, input bit noise);
    int n;
    n = 0;
    do begin
      tick(); n++;
      if (noise && busy_a && $urandom_range(0, 7) == 0)
        inject($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 20));
    end while ((busy_a || n < 2) && n < budget);
    if (n >= budget) chk("a_timeout", 1, 0);
    repeat (2) tick();
  endtask

  initial begin
    int n, h, w, g;
    #1 reset_n = 0;
    #2;
    chk("rst_ctl", {busy_a, done_a, rd_a, fs_a, vld_a}, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_dout", dout_a, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    tick();

    // 3x4, no gap: contiguous 0..11, done 15 cycles after start.
    clr(); pulse_a(3, 4, 0); wait_idle_a(100, 0);
    chk("t1_cycles", done_c - t0, 15);
    chk("t1_npix", vq.size(), 12);
    foreach (vq[i]) chk("t1_dout", vq[i], i);
    if (vcq.size() > 0) chk("t1_first_vld", vcq[0] - t0, 4);
    chk("t1_fst_cnt", fst_cnt, 1);
    chk("t1_fst_dat", fst_dat, 0);

    // 3x4, row_gap 2: 4 on / 2 off, output shifted 3 cycles, done at 19.
    clr(); pulse_a(3, 4, 2); wait_idle_a(100, 0);
    chk("t2_cycles", done_c - t0, 19);
    chk("t2_nrd", rcq.size(), 12);
    foreach (rcq[i]) if (i < 12) chk("t2_rd_cyc", rcq[i] - t0, 1 + off[i]);
    foreach (vcq[i]) if (i < rcq.size()) chk("t2_vld_shift", vcq[i] - rcq[i], 3);

    // Rejected configurations: done next cycle, no reads, never busy.
    clr(); pulse_a(0, 300, 0); wait_idle_a(20, 0);
    chk("t3_done", done_c - t0, 1);
    chk("t3_nrd", rcq.size(), 0);
    chk("t3_busy", busy_seen, 0);
    clr(); pulse_a(2, 2, 16); wait_idle_a(20, 0);
    chk("t3_gap_done", done_c - t0, 1);
    chk("t3_gap_nrd", rcq.size(), 0);

    // Start pulses mid-frame and in the done cycle are ignored.
    clr(); pulse_a(3, 4, 0);
    while (cyc < t0 + 5) tick();
    inject(2, 2, 1);
    while (cyc < t0 + 15) tick();
    inject(2, 2, 1);
    repeat (6) tick();
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_cycles", done_c - t0, 15);
    chk("t4_nrd", rcq.size(), 12);
    chk("t4_npix", vq.size(), 12);
    foreach (vq[i]) chk("t4_dout", vq[i], i);

    // Reset after 5 pixels: outputs clear at once, quiet until a new start.
    clr(); pulse_a(3, 4, 0);
    n = 0;
    while (vq.size() < 5 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("t5_timeout", 1, 0);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_ctl", {busy_a, done_a, rd_a, fs_a, vld_a}, 0);
    chk("t5_rst_dout", dout_a, 0);
    chk("t5_rst_addr", addr_a, 0);
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1;
    clr(); repeat (10) tick();
    chk("t5_quiet", vq.size() + rcq.size(), 0);
    clr(); pulse_a(3, 4, 0); wait_idle_a(100, 0);
    if (raq.size() > 0) chk("t5_addr0", raq[0], 0);
    if (vq.size() > 0) chk("t5_first_dout", vq[0], 0);
    chk("t5_fst_cnt", fst_cnt, 1);
    chk("t5_fst_dat", fst_dat, 0);
    chk("t5_cycles", done_c - t0, 15);

    // Randomized frames with stray start pulses while busy.
    for (int k = 0; k < 12; k++) begin
      h = $urandom_range(1, 5); w = $urandom_range(1, 6); g = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: h = 0;
        1: w = $urandom_range(225, 511);
        2: g = $urandom_range(16, 31);
        default: ;
      endcase
      inject(h, w, g);
      wait_idle_a(200, 1);
    end

    // Full-size frame on the latency-1 instance.
    t0 = cyc;
    fh_b = 224; fw_b = 224; rg_b = 15; start_b = 1;
    tick();
    start_b = 0;
    n = 0;
    while ((busy_b || n < 2) && n < 60000) begin tick(); n++; end
    if (n >= 60000) chk("t6_timeout", 1, 0);
    repeat (2) tick();
    chk("t6_nrd", rd_cnt_b, 50176);
    chk("t6_npix", vld_cnt_b, 50176);
    chk("t6_last_addr", last_addr_b, 50175);
    chk("t6_cycles", done_c_b - t0, 1 + 50176 + 223 * 15 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
